// File: rtl/apb_regfile_slave.sv
// ---------------------------------------------------------------------------
// apb_regfile_slave
//   APB slave exposing NUM_REGS read/write registers with byte-lane strobes,
//   WAIT_CYCLES wait states in every access phase and an error response for
//   illegal addresses. The register contents are driven out flattened for
//   downstream control logic.
//
// Handshake: a transfer is one setup cycle (psel=1, penable=0) followed by
//   access cycles (psel=1, penable=1). The transfer completes in the access
//   cycle where pready=1; prdata/pslverr are meaningful only in that cycle
//   and are forced to 0 at all other times. Dropping psel during the access
//   phase aborts the transfer with no side effects.
//
// Ports:
//   pclk, preset       clock, asynchronous active-high reset
//   psel, penable      APB select / access-phase indicator
//   paddr, pwrite      byte address, 1 = write
//   pwdata, pstrb      write data and byte-lane strobes
//   prdata, pready     read data, transfer complete
//   pslverr            error response (illegal address)
//   regs_o             register i at [i*DATA_W +: DATA_W]
//   wr_pulse_o         one-cycle pulse per register after a committed write
// ---------------------------------------------------------------------------
module apb_regfile_slave #(
   parameter int                DATA_W      = 32,
   parameter int                ADDR_W      = 32,
   parameter int                NUM_REGS    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h0000_1000,
   parameter int                WAIT_CYCLES = 0
) (
   input  logic                         pclk,
   input  logic                         preset,
   input  logic                         psel,
   input  logic                         penable,
   input  logic [ADDR_W-1:0]            paddr,
   input  logic                         pwrite,
   input  logic [DATA_W-1:0]            pwdata,
   input  logic [DATA_W/8-1:0]          pstrb,
   output logic [DATA_W-1:0]            prdata,
   output logic                         pready,
   output logic                         pslverr,
   output logic [NUM_REGS*DATA_W-1:0]   regs_o,
   output logic [NUM_REGS-1:0]          wr_pulse_o
);

   localparam int STRB_W = DATA_W / 8;
   localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [3:0]        cnt_q;
   logic [3:0]        cnt_d;

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [NUM_REGS-1:0] wr_pulse_q;

   // ------------------------------------------------------------------
   // Address decode. A paddr below BASE_ADDR wraps the subtraction to a
   // huge offset, but the explicit >= test rejects it regardless.
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] off;
   logic [ADDR_W-1:0] idx_full;
   logic [IDX_W-1:0]  idx;
   logic              addr_ok;

   assign off      = paddr - BASE_ADDR;
   assign idx_full = off >> 2;
   assign idx      = idx_full[IDX_W-1:0];
   assign addr_ok  = (paddr >= BASE_ADDR) && (off[1:0] == 2'b00) &&
                     (idx_full < ADDR_W'(NUM_REGS));

   // The completing access cycle; everything bus-visible keys off this,
   // so ST_IDLE has no path from bus inputs to outputs.
   logic access_done;
   logic wr_en;

   assign access_done = (state_q == ST_ACCESS) && psel && penable && (cnt_q == 4'd0);
   assign wr_en       = access_done && pwrite && addr_ok;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state and wait counter
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (psel && !penable) begin
               state_d = ST_ACCESS;
               cnt_d   = 4'(WAIT_CYCLES);
            end
         end
         ST_ACCESS: begin
            if (!psel) begin
               // Abort: nothing committed.
               state_d = ST_IDLE;
            end else if (!penable) begin
               // A fresh setup phase restarts the wait count.
               cnt_d = 4'(WAIT_CYCLES);
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Register bank and write pulses
   // ------------------------------------------------------------------
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= '0;
         end
         wr_pulse_q <= '0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            // Pulse even with all strobes low: the write still happened.
            wr_pulse_q[r] <= wr_en && (idx == IDX_W'(r));
            if (wr_en && (idx == IDX_W'(r))) begin
               for (int b = 0; b < STRB_W; b++) begin
                  if (pstrb[b]) begin
                     regs_q[r][8*b +: 8] <= pwdata[8*b +: 8];
                  end
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Bus response
   // ------------------------------------------------------------------
   assign pready  = access_done;
   assign pslverr = access_done && !addr_ok;
   assign prdata  = (access_done && !pwrite && addr_ok) ? regs_q[idx] : '0;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
   end

   assign wr_pulse_o = wr_pulse_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_regfile_slave
//   Two slaves share the bus wires: u_dut0 (no wait states) and u_dutw
//   (3 wait states), each with its own psel. Directed vectors, hand-written
//   corner sequences and random transfers checked against an array model.
// ---------------------------------------------------------------------------
module tb_apb_regfile_slave;

   localparam logic [31:0] BASE = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        preset = 1'b0;
   logic        psel0 = 1'b0;
   logic        pselw = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [31:0] paddr = '0;
   logic [31:0] pwdata = '0;
   logic [3:0]  pstrb = '0;

   logic [31:0]  prdata0, prdataw;
   logic         pready0, preadyw;
   logic         pslverr0, pslverrw;
   logic [255:0] regs0, regsw;
   logic [7:0]   pulse0, pulsew;

   apb_regfile_slave #(.WAIT_CYCLES(0)) u_dut0 (
      .pclk(clk), .preset(preset), .psel(psel0), .penable(penable),
      .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
      .regs_o(regs0), .wr_pulse_o(pulse0)
   );

   apb_regfile_slave #(.WAIT_CYCLES(3)) u_dutw (
      .pclk(clk), .preset(preset), .psel(pselw), .penable(penable),
      .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdataw), .pready(preadyw), .pslverr(pslverrw),
      .regs_o(regsw), .wr_pulse_o(pulsew)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int pulse7_cnt = 0;
   logic [31:0] mdl [8];

   always @(negedge clk) begin
      if (pulse0[7]) pulse7_cnt++;
   end

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit legal(input logic [31:0] a);
      return (a >= BASE) && (a[1:0] == 2'b00) && (((a - BASE) >> 2) < 32'd8);
   endfunction

   function automatic logic [255:0] mdl_flat();
      logic [255:0] f;
      for (int i = 0; i < 8; i++) f[i*32 +: 32] = mdl[i];
      return f;
   endfunction

   task automatic mdl_apply(input bit wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
      int i;
      if (wr && legal(a)) begin
         i = int'((a - BASE) >> 2);
         for (int b = 0; b < 4; b++) if (s[b]) mdl[i][8*b +: 8] = d[8*b +: 8];
      end
   endtask

   function automatic logic [31:0] mdl_read(input logic [31:0] a);
      if (!legal(a)) return 32'h0;
      return mdl[int'((a - BASE) >> 2)];
   endfunction

   // ---------------- driver tasks ----------------
   // Setup phase on the next edge, then access phase until pready. Returns
   // at the falling edge of the pready cycle, leaving the bus driven so a
   // following call issues its setup phase with no idle gap.
   task automatic xfer(input bit use_w, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output logic err, output int waits);
      bit done;
      @(posedge clk); #1;
      psel0 = !use_w; pselw = use_w; penable = 1'b0;
      pwrite = wr; paddr = a; pwdata = d; pstrb = s;
      @(posedge clk); #1;
      penable = 1'b1;
      waits = 0; done = 1'b0; rd = '0; err = 1'b0;
      while (!done && waits < 40) begin
         @(negedge clk);
         if (use_w ? preadyw : pready0) begin
            rd   = use_w ? prdataw : prdata0;
            err  = use_w ? pslverrw : pslverr0;
            done = 1'b1;
         end else begin
            check("resp_before_ready", use_w ? {pslverrw, prdataw} : {pslverr0, prdata0}, '0);
            waits++;
         end
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL pready_timeout: got no pready after %0d cycles expected pready", waits);
      end
   endtask

   task automatic bus_idle();
      @(posedge clk); #1;
      psel0 = 1'b0; pselw = 1'b0; penable = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_rd;
      bit          exp_err;
      logic [7:0]  exp_pulse;
   } vec_t;

   vec_t vecs [10];

   initial begin
      logic [31:0] rd, a, d;
      logic        err, wr;
      logic [3:0]  s;
      int          waits, kind;

      vecs[0] = '{1'b1, BASE + 32'd4,  32'hDEAD_BEEF, 4'hF,    32'h0,         1'b0, 8'h02};
      vecs[1] = '{1'b0, BASE + 32'd4,  32'h0,         4'h0,    32'hDEAD_BEEF, 1'b0, 8'h00};
      vecs[2] = '{1'b1, BASE + 32'd4,  32'h1122_3344, 4'b0101, 32'h0,         1'b0, 8'h02};
      vecs[3] = '{1'b0, BASE + 32'd4,  32'h0,         4'h0,    32'hDE22_BE44, 1'b0, 8'h00};
      vecs[4] = '{1'b1, BASE + 32'd32, 32'h5555_AAAA, 4'hF,    32'h0,         1'b1, 8'h00};
      vecs[5] = '{1'b0, BASE + 32'd32, 32'h0,         4'h0,    32'h0,         1'b1, 8'h00};
      vecs[6] = '{1'b1, BASE - 32'd4,  32'h0F0F_0F0F, 4'hF,    32'h0,         1'b1, 8'h00};
      vecs[7] = '{1'b0, BASE + 32'd2,  32'h0,         4'h0,    32'h0,         1'b1, 8'h00};
      vecs[8] = '{1'b1, BASE + 32'd2,  32'h7777_7777, 4'hF,    32'h0,         1'b1, 8'h00};
      vecs[9] = '{1'b1, BASE + 32'd12, 32'hFFFF_FFFF, 4'h0,    32'h0,         1'b0, 8'h08};
      for (int i = 0; i < 8; i++) mdl[i] = '0;

      // ---------------- reset ----------------
      #1 preset = 1'b1;
      #1;
      check("reset_outputs0", {pready0, pslverr0, prdata0, pulse0}, '0);
      check("reset_regs0", regs0, '0);
      check("reset_outputsw", {preadyw, pslverrw, prdataw, pulsew, regsw}, '0);
      repeat (2) @(posedge clk);
      @(negedge clk) preset = 1'b0;

      // ---------------- vector table, zero wait states ----------------
      for (int i = 0; i < 10; i++) begin
         xfer(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, rd, err, waits);
         check($sformatf("v%0d_waits", i), waits, 0);
         check($sformatf("v%0d_err", i), err, vecs[i].exp_err);
         if (!vecs[i].wr) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
         mdl_apply(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb);
         bus_idle();
         check($sformatf("v%0d_pulse", i), pulse0, vecs[i].exp_pulse);
         check($sformatf("v%0d_regs", i), regs0, mdl_flat());
      end

      // ---------------- back-to-back write then read of reg 7 ----------------
      pulse7_cnt = 0;
      xfer(1'b0, 1'b1, BASE + 32'd28, 32'hA5A5_5A5A, 4'hF, rd, err, waits);
      check("b2b_wr_err", err, 1'b0);
      mdl_apply(1'b1, BASE + 32'd28, 32'hA5A5_5A5A, 4'hF);
      xfer(1'b0, 1'b0, BASE + 32'd28, 32'h0, 4'h0, rd, err, waits);
      check("b2b_rd_data", rd, 32'hA5A5_5A5A);
      check("b2b_rd_err", err, 1'b0);
      bus_idle();
      repeat (3) @(negedge clk);
      check("b2b_pulse7_count", pulse7_cnt, 1);

      // ---------------- three wait states ----------------
      xfer(1'b1, 1'b0, BASE + 32'd8, 32'h0, 4'h0, rd, err, waits);
      check("w3_rd_waits", waits, 3);
      check("w3_rd_data", rd, 32'h0);
      xfer(1'b1, 1'b1, BASE + 32'd8, 32'h1234_5678, 4'hF, rd, err, waits);
      check("w3_wr_waits", waits, 3);
      bus_idle();
      check("w3_wr_pulse", pulsew, 8'h04);
      xfer(1'b1, 1'b0, BASE + 32'd8, 32'h0, 4'h0, rd, err, waits);
      check("w3_rd2_data", rd, 32'h1234_5678);
      check("w3_rd2_err", err, 1'b0);
      bus_idle();

      // ---------------- reset during a write's wait state ----------------
      @(posedge clk); #1;
      pselw = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = BASE + 32'd12; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      check("rst_mid_pre_ready", preadyw, 1'b0);
      #2 preset = 1'b1;
      #1;
      check("rst_mid_ready", preadyw, 1'b0);
      check("rst_mid_regs", regsw, '0);
      check("rst_mid_pulse", pulsew, '0);
      for (int i = 0; i < 8; i++) mdl[i] = '0;
      check("rst_mid_regs0", regs0, mdl_flat());
      pselw = 1'b0; penable = 1'b0;
      @(negedge clk) preset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_lost_write", regsw, '0);
      xfer(1'b1, 1'b1, BASE + 32'd12, 32'hCAFE_F00D, 4'hF, rd, err, waits);
      check("rst_after_waits", waits, 3);
      bus_idle();
      check("rst_after_pulse", pulsew, 8'h08);
      check("rst_after_reg3", regsw[127:96], 32'hCAFE_F00D);

      // ---------------- random transfers against the model ----------------
      for (int n = 0; n < 80; n++) begin
         kind = $urandom_range(0, 9);
         if (kind < 7)       a = BASE + 32'(4 * $urandom_range(0, 7));
         else if (kind == 7) a = BASE + 32'd32 + 32'(4 * $urandom_range(0, 100));
         else if (kind == 8) a = BASE - 32'(4 * $urandom_range(1, 50));
         else                a = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
         wr = 1'($urandom_range(0, 1));
         d  = $urandom;
         s  = 4'($urandom_range(0, 15));
         xfer(1'b0, wr, a, d, s, rd, err, waits);
         check("rnd_err", err, !legal(a));
         if (!wr) check("rnd_rdata", rd, mdl_read(a));
         mdl_apply(wr, a, d, s);
         if ($urandom_range(0, 1) == 1) bus_idle();
      end
      bus_idle();
      repeat (2) @(negedge clk);
      check("rnd_final_regs", regs0, mdl_flat());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
